// File: rtl/rinv_pkg.sv
// Shared types, constants and saturation helpers for r_inverse_backsub.
// Build with RINV_ROUND_EN defined for round-half-up arithmetic (latency +3).
package rinv_pkg;

  localparam int WORD_LENGTH     = 16;
  localparam int FRACTION_LENGTH = 12;
  localparam int DIV_ITER_DEF    = WORD_LENGTH + FRACTION_LENGTH;

`ifdef RINV_ROUND_EN
  localparam int ROUND_ITER = 1;
`else
  localparam int ROUND_ITER = 0;
`endif

  // Edges from the one that accepts valid to the one that raises done.
  localparam int LAT = 3 * (DIV_ITER_DEF + 1 + ROUND_ITER) + 9;

  typedef enum logic [2:0] {
    IDLE,
    RECIP1,
    RECIP2,
    RECIP3,
    MUL,
    DONE
  } state_t;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(WORD_LENGTH);
  localparam longint SAT_MIN = sat_min(WORD_LENGTH);

  // Clamp a wide signed value into the range of a w-bit two's-complement word.
  function automatic longint sat_w(input longint x, input int w);
    longint hi;
    longint lo;
    hi = sat_max(w);
    lo = sat_min(w);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fxp_recip_seq.sv
// Sequential restoring reciprocal: result = sat(2^(2F) / divisor), one quotient bit per cycle.
// With RINV_ROUND_EN one extra iteration produces a round bit and the quotient is rounded.
module fxp_recip_seq
  import rinv_pkg::*;
#(
  parameter int W    = WORD_LENGTH,
  parameter int F    = FRACTION_LENGTH,
  parameter int ITER = W + F
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         zero,
  output logic [W-1:0] result
);

`ifdef RINV_ROUND_EN
  localparam int N = ITER + 1;
`else
  localparam int N = ITER;
`endif
  localparam int CW = $clog2(N + 1);
  localparam int N1 = N + 1;

  localparam logic [N-1:0] DIVIDEND = N'(longint'(1) << (2 * F + N - ITER));
  localparam logic [W-1:0] POS_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MAX  = {1'b1, {(W-1){1'b0}}};
  localparam logic [N-1:0] POS_LIM  = N'(POS_MAX);
  localparam logic [N-1:0] NEG_LIM  = N'(NEG_MAX);

  logic [W-1:0]  den_q;
  logic [W-1:0]  rem_q;
  logic [N-1:0]  num_q;
  logic [N-1:0]  quo_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q;
  logic [W:0]    rem_shift;
  logic          rem_ge;
  logic [N-1:0]  q_mag;
  logic [W-1:0]  den_abs;

  assign den_abs   = divisor[W-1] ? (W'(0) - divisor) : divisor;
  assign rem_shift = {rem_q, num_q[N-1]};
  assign rem_ge    = (rem_shift >= {1'b0, den_q});

`ifdef RINV_ROUND_EN
  assign q_mag = N'(({1'b0, quo_q} + N1'(1)) >> 1);
`else
  assign q_mag = quo_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      den_q <= '0;
      rem_q <= '0;
      num_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      zero  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        den_q <= den_abs;
        neg_q <= divisor[W-1];
        zero  <= (divisor == '0);
        rem_q <= '0;
        num_q <= DIVIDEND;
        quo_q <= '0;
        cnt_q <= CW'(N);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_ge ? W'(rem_shift - {1'b0, den_q}) : W'(rem_shift);
        num_q <= {num_q[N-2:0], 1'b0};
        quo_q <= {quo_q[N-2:0], rem_ge};
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    result = q_mag[W-1:0];
    if (zero) begin
      result = POS_MAX;
    end else if (!neg_q) begin
      if (q_mag > POS_LIM) result = POS_MAX;
    end else if (q_mag > NEG_LIM) begin
      result = NEG_MAX;
    end else begin
      result = W'(0) - q_mag[W-1:0];
    end
  end

endmodule

// File: rtl/r_inverse_backsub.sv
// U = R^-1 for a 3x3 upper-triangular R: three shared reciprocals, then seven multiplies.
// RINV_ROUND_EN switches multiplies and divider to round-half-up (latency +3).
module r_inverse_backsub
  import rinv_pkg::*;
#(
  parameter int wordLength     = WORD_LENGTH,
  parameter int fractionLength = FRACTION_LENGTH,
  parameter int DIV_ITER       = wordLength + fractionLength
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [wordLength-1:0] r11,
  input  logic [wordLength-1:0] r12,
  input  logic [wordLength-1:0] r13,
  input  logic [wordLength-1:0] r22,
  input  logic [wordLength-1:0] r23,
  input  logic [wordLength-1:0] r33,
  output logic [wordLength-1:0] u11,
  output logic [wordLength-1:0] u12,
  output logic [wordLength-1:0] u13,
  output logic [wordLength-1:0] u22,
  output logic [wordLength-1:0] u23,
  output logic [wordLength-1:0] u33,
  output logic                  done,
  output logic                  div_zero
);

  localparam int W  = wordLength;
  localparam int F  = fractionLength;
  localparam int W2 = 2 * W;
`ifdef RINV_ROUND_EN
  localparam logic signed [W2-1:0] RND = W2'(longint'(1) << (F - 1));
`endif

  typedef logic signed [W-1:0] word_t;

  // Signed W x W product, scaled back by F and saturated to W bits.
  function automatic word_t mul_sh(input word_t a, input word_t b);
    logic signed [W2-1:0] p;
    p = W2'(a) * W2'(b);
`ifdef RINV_ROUND_EN
    p = p + RND;
`endif
    return W'(sat_w(longint'(p >>> F), W));
  endfunction

  function automatic word_t neg_sat(input word_t x);
    return W'(sat_w(-longint'(x), W));
  endfunction

  state_t       state_q, state_d;
  logic [2:0]   step_q;
  logic         start_q;
  word_t        r11_q, r12_q, r13_q, r22_q, r23_q, r33_q;
  word_t        u11_q, u12_q, u13_q, u22_q, u23_q, u33_q;
  word_t        t_q;
  word_t        mul_a, mul_b, prod;
  logic         div_start, div_busy, div_done, div_is_zero;
  logic [W-1:0] div_operand, div_result;

  fxp_recip_seq #(.W(W), .F(F), .ITER(DIV_ITER)) u_recip (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .divisor (div_operand),
    .busy    (div_busy),
    .done    (div_done),
    .zero    (div_is_zero),
    .result  (div_result)
  );

  // The next reciprocal is launched in the same cycle the previous one is captured.
  always_comb begin
    state_d     = state_q;
    div_start   = start_q && !div_busy;
    div_operand = r11_q;
    case (state_q)
      IDLE:   if (valid) state_d = RECIP1;
      RECIP1: if (div_done) begin
        state_d     = RECIP2;
        div_start   = 1'b1;
        div_operand = r22_q;
      end
      RECIP2: if (div_done) begin
        state_d     = RECIP3;
        div_start   = 1'b1;
        div_operand = r33_q;
      end
      RECIP3: if (div_done) state_d = MUL;
      MUL:    if (step_q == 3'd6) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_a = r12_q;
    mul_b = u22_q;
    case (step_q)
      3'd1: begin mul_a = t_q;   mul_b = u11_q; end
      3'd2: begin mul_a = r23_q; mul_b = u33_q; end
      3'd3: begin mul_a = t_q;   mul_b = u22_q; end
      3'd4: begin mul_a = r12_q; mul_b = u23_q; end
      3'd5: begin mul_a = r13_q; mul_b = u33_q; end
      3'd6: begin mul_a = t_q;   mul_b = u11_q; end
      default: ;
    endcase
  end

  assign prod = mul_sh(mul_a, mul_b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      start_q  <= 1'b0;
      r11_q    <= '0;
      r12_q    <= '0;
      r13_q    <= '0;
      r22_q    <= '0;
      r23_q    <= '0;
      r33_q    <= '0;
      u11_q    <= '0;
      u12_q    <= '0;
      u13_q    <= '0;
      u22_q    <= '0;
      u23_q    <= '0;
      u33_q    <= '0;
      t_q      <= '0;
      u11      <= '0;
      u12      <= '0;
      u13      <= '0;
      u22      <= '0;
      u23      <= '0;
      u33      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= 1'b0;
      done    <= 1'b0;
      if (div_done && div_is_zero) div_zero <= 1'b1;
      case (state_q)
        IDLE: begin
          r11_q <= r11;
          r12_q <= r12;
          r13_q <= r13;
          r22_q <= r22;
          r23_q <= r23;
          r33_q <= r33;
          step_q <= '0;
          if (valid) begin
            start_q  <= 1'b1;
            div_zero <= 1'b0;
          end
        end
        RECIP1: if (div_done) u11_q <= div_result;
        RECIP2: if (div_done) u22_q <= div_result;
        RECIP3: if (div_done) u33_q <= div_result;
        MUL: begin
          step_q <= step_q + 3'd1;
          case (step_q)
            3'd1:    u12_q <= neg_sat(prod);
            3'd3:    u23_q <= neg_sat(prod);
            3'd5:    t_q   <= W'(sat_w(longint'(t_q) + longint'(prod), W));
            3'd6:    u13_q <= neg_sat(prod);
            default: t_q   <= prod;
          endcase
        end
        DONE: begin
          u11  <= u11_q;
          u12  <= u12_q;
          u13  <= u13_q;
          u22  <= u22_q;
          u23  <= u23_q;
          u33  <= u33_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/r_inverse_backsub.md
Name: r_inverse_backsub

Overview:
- Consumes the upper-triangular R factor produced by the Givens-rotation QR stage (the a, b, c, e, f, i outputs) and computes U = R^-1.
- Uses back substitution: three sequential reciprocals, then a fixed sequence of seven multiplies.
- U feeds the final multiply stage of the matrix-inversion pipeline, A^-1 = R^-1 * Q^T.
- All values are signed two's-complement fixed point, same format as the QR stage.

Parameters:
- wordLength, 16, total bits per element.
- fractionLength, 12, fraction bits (1.0 = 0x1000 at defaults).
- DIV_ITER, wordLength+fractionLength, quotient bits the divider produces (one per cycle).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  start request; sampled only in IDLE.
- r11, r12, r13, r22, r23, r33  in  wordLength each  R elements (QR outputs a, b, c, e, f, i).
- u11, u12, u13, u22, u23, u33  out  wordLength each  R^-1 elements; registered.
- done  out  1  one-cycle pulse when the u* outputs update.
- div_zero  out  1  sticky flag: a zero diagonal element was seen in the current job.

Behaviour:
- Reset (async, active-low): state=IDLE; all u* = 0; done = 0; div_zero = 0; internal registers = 0.
- IDLE:
  - r* are captured continuously.
  - valid=1 at a rising edge latches r*, clears div_zero, and moves to RECIP1.
  - valid is ignored in every other state; there is no queuing.
- RECIP1/2/3: reciprocal of r11, r22, r33 respectively.
  - One load cycle, then DIV_ITER restoring-division cycles.
  - Divider computes 2^(2F) / |r|; the sign is applied afterwards; result saturates to [-2^(W-1), 2^(W-1)-1].
  - Divisor 0: result = 0x7FFF (max positive); div_zero sets and stays set until the next accepted valid.
- MUL: 7 cycles, step counter 0..6, one W x W signed product per cycle.
  - Each product (2W bits) is arithmetic-shifted right by F, then saturated to W bits.
  - step0: t = r12*u22
  - step1: u12 = -(t*u11)
  - step2: t = r23*u33
  - step3: u23 = -(t*u22)
  - step4: t = r12*u23
  - step5: acc = sat(t + r13*u33)
  - step6: u13 = -(acc*u11)
  - Negation saturates: -(-2^(W-1)) = 2^(W-1)-1.
- Output registers:
  - u* hold their previous values during computation.
  - All six u* are written on the DONE cycle.
  - DONE returns to IDLE on the next edge.
- Latency: done is high on the 3*(DIV_ITER+1)+9 th edge after the edge that accepted valid; this is 96 at defaults. Throughput is one job per latency+1 cycles.
- Reset mid-operation: aborts immediately, values return to their reset values, and any partial results are discarded.
- valid held high through DONE: a new job is accepted on the first IDLE edge.

Optional Feature:
- Macro: RINV_ROUND_EN.
- Defined: every multiply adds 2^(F-1) before the right shift (round half up), and the divider applies a final round bit (one extra iteration, with the quotient rounded); latency grows by 3 cycles.
- Undefined: plain truncation (arithmetic shift), with latency as stated above.

Decomposition:
- Package rinv_pkg holds:
  - state encodings IDLE, RECIP1, RECIP2, RECIP3, MUL, DONE;
  - the LAT constant;
  - saturation limits SAT_MAX and SAT_MIN as functions of wordLength;
  - a sat_w function.
- One sub-module, fxp_recip_seq: a sequential restoring reciprocal with start/busy/done, sign handling, zero detect and saturation, instantiated once and shared by the three RECIP states.
- The multiply step sequencer stays in the top module.

Test Plan:
- Identity: r11=r22=r33=0x1000, off-diagonals 0 -> u11=u22=u33=0x1000, others 0x0000; done on edge 96; div_zero=0.
- General case: r11=0x2000, r12=0x1000, r13=0, r22=0x4000, r23=0x2000, r33=0x1000 -> u11=0x0800, u22=0x0400, u33=0x1000, u12=0xFE00, u23=0xF800, u13=0x0400.
- Zero pivot: r22=0, otherwise identity -> u22=0x7FFF, div_zero=1, done still on edge 96; the next job with r22=0x1000 clears div_zero.
- Saturation: r11=0x0001 -> u11=0x7FFF (no wrap); r11=0xFFFF -> u11=0x8000.
- Busy/valid: hold valid high throughout -> exactly one done per 97 cycles; changing r* mid-job does not alter the results of the job in progress.
- Reset mid-job: assert reset at cycle 40 -> all u*=0, done=0, state IDLE; a following identity job completes correctly on edge 96.
